// File: rtl/mux_pkg.sv
// Shared definitions for the mux tree leaves (select width, slice addressing).
// Pure declarations; no logic, no latency.
package mux_pkg;

  localparam int MUX4_SEL_W = 2;

  // Low bit of slice k in a packed bus of width-bit slices.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/mux_2to1.sv
// 2:1 selector leaf, out = sel ? i1 : i0.
// Combinational, zero latency, no flow control.
module mux_2to1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? i1 : i0;

endmodule

// File: rtl/mux_4x1.sv
// 4:1 selector built from two levels of 2:1, with a combinational out and a registered out_q/out_valid.
// out: zero latency; out_q/out_valid: 1 cycle; no backpressure, one select per cycle.
module mux_4x1
  import mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter bit REG_HOLD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [MUX4_SEL_W-1:0] addr,
  input  logic [4*WIDTH-1:0]    mux_ins,
  output logic [WIDTH-1:0]      out,
  output logic [WIDTH-1:0]      out_q,
  output logic                  out_valid
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  // addr[0] picks within each pair, addr[1] picks the pair.
  mux_2to1 #(.WIDTH(WIDTH)) u_lo (
    .i0  (mux_ins[slice_lo(0, WIDTH) +: WIDTH]),
    .i1  (mux_ins[slice_lo(1, WIDTH) +: WIDTH]),
    .sel (addr[0]),
    .out (lo)
  );

  mux_2to1 #(.WIDTH(WIDTH)) u_hi (
    .i0  (mux_ins[slice_lo(2, WIDTH) +: WIDTH]),
    .i1  (mux_ins[slice_lo(3, WIDTH) +: WIDTH]),
    .sel (addr[0]),
    .out (hi)
  );

  mux_2to1 #(.WIDTH(WIDTH)) u_top (
    .i0  (lo),
    .i1  (hi),
    .sel (addr[1]),
    .out (out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid || !REG_HOLD) begin
        out_q <= out;
      end
    end
  end

  addr_known_a : assert property (@(posedge clk) disable iff (!rst_n) in_valid |-> !$isunknown(addr));

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: vector table, directed register sequences, randomized run vs. reference model.
module tb_mux_4x1;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  addr;
  logic [3:0]  ins1;
  logic [31:0] ins8;
  logic        out1, q1, v1;
  logic [7:0]  out8, q8, out8n, q8n;
  logic        v8, v8n;

  int checks = 0;
  int errors = 0;

  mux_4x1 #(.WIDTH(1), .REG_HOLD(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .addr(addr),
    .mux_ins(ins1), .out(out1), .out_q(q1), .out_valid(v1)
  );

  mux_4x1 #(.WIDTH(8), .REG_HOLD(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .addr(addr),
    .mux_ins(ins8), .out(out8), .out_q(q8), .out_valid(v8)
  );

  mux_4x1 #(.WIDTH(8), .REG_HOLD(1'b0)) u_w8n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .addr(addr),
    .mux_ins(ins8), .out(out8n), .out_q(q8n), .out_valid(v8n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          wide;
    logic [31:0] ins;
    logic [1:0]  a;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: slice a of a bus of w-bit fields, via shift and mask.
  function automatic logic [7:0] pick(input logic [31:0] bus, input int a, input int w);
    logic [31:0] t;
    t = (bus >> (a * w)) & ((32'd1 << w) - 32'd1);
    return t[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] m_q1, m_q8, m_q8n;
  logic       m_v;

  initial begin
    tbl[0] = '{"w1_0100_a2", 1'b0, 32'h4, 2'd2, 8'h01};
    tbl[1] = '{"w1_0100_a1", 1'b0, 32'h4, 2'd1, 8'h00};
    tbl[2] = '{"w8_a0", 1'b1, 32'hDDCCBBAA, 2'd0, 8'hAA};
    tbl[3] = '{"w8_a1", 1'b1, 32'hDDCCBBAA, 2'd1, 8'hBB};
    tbl[4] = '{"w8_a2", 1'b1, 32'hDDCCBBAA, 2'd2, 8'hCC};
    tbl[5] = '{"w8_a3", 1'b1, 32'hDDCCBBAA, 2'd3, 8'hDD};

    rst_n = 1'b0; in_valid = 1'b0; addr = 2'd0; ins1 = 4'd0; ins8 = 32'd0;
    #2;
    chk("rst_q1", {31'd0, q1}, 32'd0);
    chk("rst_v1", {31'd0, v1}, 32'd0);
    chk("rst_q8", {24'd0, q8}, 32'd0);
    chk("rst_v8", {31'd0, v8}, 32'd0);
    chk("rst_q8n", {24'd0, q8n}, 32'd0);

    // Combinational path works while rst_n is low.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] iv;
      iv = i[5:0];
      {ins1, addr} = iv;
      #1;
      chk("exh_w1", {31'd0, out1}, {24'd0, pick({28'd0, ins1}, int'(addr), 1)});
    end

    foreach (tbl[k]) begin
      addr = tbl[k].a;
      if (tbl[k].wide) ins8 = tbl[k].ins;
      else ins1 = tbl[k].ins[3:0];
      #1;
      if (tbl[k].wide) chk(tbl[k].name, {24'd0, out8}, {24'd0, tbl[k].exp});
      else chk(tbl[k].name, {31'd0, out1}, {24'd0, tbl[k].exp});
    end

    // Registered latency and hold.
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; addr = 2'd3; ins8 = 32'hDDCCBBAA;
    step();
    chk("lat_q8", {24'd0, q8}, 32'hDD);
    chk("lat_v8", {31'd0, v8}, 32'd1);
    in_valid = 1'b0; addr = 2'd0;
    step();
    chk("hold_q8", {24'd0, q8}, 32'hDD);
    chk("hold_v8", {31'd0, v8}, 32'd0);
    chk("nohold_q8n", {24'd0, q8n}, 32'hAA);

    // Async reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q8", {24'd0, q8}, 32'd0);
    chk("arst_v8", {31'd0, v8}, 32'd0);
    chk("arst_q8n", {24'd0, q8n}, 32'd0);
    addr = 2'd2;
    #1;
    chk("arst_out8", {24'd0, out8}, 32'hCC);

    // Release, first valid select lands one cycle later.
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; addr = 2'd1;
    step();
    chk("rel_q8", {24'd0, q8}, 32'hBB);
    chk("rel_v8", {31'd0, v8}, 32'd1);

    // Back-to-back loads on REG_HOLD=0, even without in_valid.
    in_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      step();
      chk("b2b_q8n", {24'd0, q8n}, {24'd0, pick(32'hDDCCBBAA, a, 8)});
      chk("b2b_v8n", {31'd0, v8n}, 32'd0);
    end

    // Randomized run against the model.
    m_q1 = {7'd0, q1}; m_q8 = q8; m_q8n = q8n; m_v = v8;
    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 24) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      addr     = 2'($urandom_range(0, 3));
      ins1     = 4'($urandom);
      ins8     = $urandom;
      if (!rst_n) begin
        m_q1 = 8'd0; m_q8 = 8'd0; m_q8n = 8'd0; m_v = 1'b0;
      end
      #1;
      chk("rnd_out1", {31'd0, out1}, {24'd0, pick({28'd0, ins1}, int'(addr), 1)});
      chk("rnd_out8", {24'd0, out8}, {24'd0, pick(ins8, int'(addr), 8)});
      chk("rnd_arst_q8", {24'd0, q8}, {24'd0, m_q8});
      if (rst_n) begin
        m_v = in_valid;
        if (in_valid) begin
          m_q1 = pick({28'd0, ins1}, int'(addr), 1);
          m_q8 = pick(ins8, int'(addr), 8);
        end
        m_q8n = pick(ins8, int'(addr), 8);
      end
      step();
      chk("rnd_q1", {31'd0, q1}, {24'd0, m_q1});
      chk("rnd_v1", {31'd0, v1}, {31'd0, m_v});
      chk("rnd_q8", {24'd0, q8}, {24'd0, m_q8});
      chk("rnd_q8n", {24'd0, q8n}, {24'd0, m_q8n});
      chk("rnd_v8n", {31'd0, v8n}, {31'd0, m_v});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_4x1.md
Name: mux_4x1

Overview:
- Parameterised 4-to-1 selector, the leaf of the team's wider mux trees; an 8:1 is two of these plus a 2:1.
- Provides a combinational output for tree composition.
- Also provides a 1-cycle registered copy with a valid flag for pipelined datapaths.
- Internally built from two levels of 2:1 selection.

Parameters:
- WIDTH, 1, bit width of each data input and of the outputs.
- REG_HOLD, 1, when 1 out_q holds its value on cycles with in_valid=0; when 0 out_q loads every cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies addr/mux_ins for the registered path.
- addr  input  2  select; addr[0] picks within a pair, addr[1] picks the pair.
- mux_ins  input  4*WIDTH  packed inputs; slice k = mux_ins[k*WIDTH +: WIDTH].
- out  output  WIDTH  combinational selected value.
- out_q  output  WIDTH  registered selected value.
- out_valid  output  1  registered in_valid.

Behaviour:
- Combinational path, out = slice[addr]. Structure, identical in result:
  - lo = addr[0] ? slice1 : slice0
  - hi = addr[0] ? slice3 : slice2
  - out = addr[1] ? hi : lo
- The combinational path has zero latency and no dependence on clk or rst_n; out is valid even while rst_n=0.
- Reset: when rst_n falls, immediately and asynchronously set out_q = 0 and out_valid = 0, regardless of clk. Deassertion takes effect at the first rising clk edge after rst_n=1.
- Registered path, evaluated at each rising clk edge with rst_n=1:
  - out_valid <= in_valid.
  - If in_valid=1 or REG_HOLD=0: out_q <= out sampled at that edge.
  - Otherwise out_q keeps its previous value.
- Latency from input to out_q/out_valid is exactly 1 cycle. Throughput is one select per cycle; there is no backpressure.
- Reset asserted mid-stream discards any in-flight value. The first valid result after release appears 1 cycle after the first in_valid=1 edge.
- X/Z on addr: out is unspecified; a simulation assertion flags unknown addr when in_valid=1.
- No arithmetic; widths are exact and nothing is truncated or extended.

Decomposition:
- Shared package mux_pkg: localparam MUX4_SEL_W = 2.
- Shared package mux_pkg: a helper function slice index (k*WIDTH).
- Sub-module mux_2to1 (params WIDTH; ports i0, i1, sel, out; out = sel ? i1 : i0).
- Instantiate mux_2to1 three times for the combinational tree. The same sub-module is reused by mux_8x1 trees.

Test Plan:
- Exhaustive combinational check, WIDTH=1: iterate {mux_ins, addr} = 0..63, one step each. Required: out == mux_ins[addr] on every step, e.g. mux_ins=4'b0100, addr=2 -> out=1; addr=1 -> out=0.
- Wide data, WIDTH=8: mux_ins = {8'hDD, 8'hCC, 8'hBB, 8'hAA}. Required: addr=0..3 gives out = AA, BB, CC, DD.
- Registered latency: in_valid=1, addr=3 with the WIDTH=8 data above at edge N. Required: out_q=8'hDD and out_valid=1 after edge N. Then in_valid=0 at edge N+1 with REG_HOLD=1. Required: out_q stays DD and out_valid=0.
- Async reset: out_q=8'hDD, then pull rst_n low between edges. Required: out_q=0 and out_valid=0 immediately, without waiting for a clk edge. out still tracks addr while in reset.
- Reset release: rst_n rises, in_valid=1 with addr=1 at the next edge. Required: out_q=8'hBB and out_valid=1 one cycle later.
- Back-to-back with REG_HOLD=0: present addr 0,1,2,3 on consecutive cycles. Required: out_q shows AA, BB, CC, DD on the following cycles, with no bubbles.
